// File: rtl/addsub_seq32_pkg.sv
// Shared constants for the sequential slice-at-a-time adder/subtractor.
// The state encoding and default geometry are used by the RTL and its bench.
package addsub_seq32_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SLICE_DEF = 4;
    localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_seq32_cla4.sv
// Combinational SLICE-bit carry-lookahead group built from per-bit propagate/generate cells.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module cla4 #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             p_grp,
    output logic             g_grp,
    output logic             c_msb_in
);

    logic [SLICE-1:0] w_p;
    logic [SLICE-1:0] w_g;
    logic [SLICE:0]   w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Each carry is a flat sum of products of generate/propagate terms, not a ripple chain.
    always_comb begin
        logic cAcc;
        logic gTerm;
        logic gAcc;
        w_c    = '0;
        w_c[0] = cin;
        cAcc   = 1'b0;
        gTerm  = 1'b0;
        gAcc   = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            cAcc = cin;
            for (int j = 0; j <= i; j++) begin
                cAcc = cAcc & w_p[j];
            end
            for (int j = 0; j <= i; j++) begin
                gTerm = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    gTerm = gTerm & w_p[k];
                end
                cAcc = cAcc | gTerm;
            end
            w_c[i+1] = cAcc;
        end
        for (int j = 0; j < SLICE; j++) begin
            gTerm = w_g[j];
            for (int k = j + 1; k < SLICE; k++) begin
                gTerm = gTerm & w_p[k];
            end
            gAcc = gAcc | gTerm;
        end
        g_grp = gAcc;
    end

    assign p_grp    = &w_p;
    assign s        = w_p ^ w_c[SLICE-1:0];
    assign cout     = w_c[SLICE];
    assign c_msb_in = w_c[SLICE-1];

endmodule

// File: rtl/addsub_seq32.sv
// Multi-cycle adder/subtractor: one shared lookahead group processes one slice per clock.
// Operands are latched on start; results stay stable from DONE until the next operation runs.
module addsub_seq32
    import addsub_seq32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ovf;
    logic             r_zero;

    logic [SLICE-1:0] w_aSl;
    logic [SLICE-1:0] w_bSl;
    logic [SLICE-1:0] w_sumSl;
    logic             w_cout;
    logic             w_grpP;
    logic             w_grpG;
    logic             w_cMsbIn;
    logic             w_coGrp;
    logic [WIDTH-1:0] w_sNext;

    assign w_aSl = r_a[r_idx*SLICE +: SLICE];
    assign w_bSl = r_b[r_idx*SLICE +: SLICE];

    cla4 #(.SLICE(SLICE)) u_cla (
        .a        (w_aSl),
        .b        (w_bSl),
        .cin      (r_carry),
        .s        (w_sumSl),
        .cout     (w_cout),
        .p_grp    (w_grpP),
        .g_grp    (w_grpG),
        .c_msb_in (w_cMsbIn)
    );

    // Final carry-out is formed from the group P/G terms; chaining uses the direct cout.
    assign w_coGrp = w_grpG | (w_grpP & r_carry);

    always_comb begin
        w_sNext = r_s;
        w_sNext[r_idx*SLICE +: SLICE] = w_sumSl;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: if (start) w_stateNext = ST_RUN;
            ST_RUN:  if (r_idx == LAST_IDX) w_stateNext = ST_DONE;
            ST_DONE: w_stateNext = start ? ST_RUN : ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    // Subtraction is a + ~b + 1: invert B at latch time and seed the carry with sub.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_s     <= w_sNext;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IW'(1);
                    if (r_idx == LAST_IDX) begin
                        r_co   <= w_coGrp;
                        r_ovf  <= w_cMsbIn ^ w_coGrp;
                        r_zero <= (w_sNext == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = r_s;
    assign co   = r_co;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_addsub_seq32.sv
// Self-checking bench for addsub_seq32: directed vector table, handshake corner
// sequences and random operations checked against a plain-arithmetic reference.
module tb_addsub_seq32;
    import addsub_seq32_pkg::*;

    localparam int MAX_WAIT = 50;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] expS;
        logic        expCo;
        logic        expOvf;
        logic        expZero;
    } vector_t;

    addsub_seq32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference computed from integer arithmetic, independent of slices and carries.
    function automatic logic [35:0] refModel(input logic [31:0] ra, input logic [31:0] rb, input logic rsub);
        longint sa;
        longint sb;
        longint sr;
        logic [31:0] rs;
        logic rco;
        logic rovf;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        if (rsub) begin
            rs  = ra - rb;
            rco = (ra >= rb);
            sr  = sa - sb;
        end else begin
            rs  = ra + rb;
            rco = ({32'd0, ra} + {32'd0, rb}) > 64'hFFFF_FFFF;
            sr  = sa + sb;
        end
        rovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {1'b0, (rs == 32'd0), rovf, rco, rs};
    endfunction

    // Launches one operation and waits (bounded) for the done pulse; returns at the DONE cycle.
    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic vsub,
                                 output int lat, output int busyCnt);
        @(negedge clk);
        a = va;
        b = vb;
        sub = vsub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        busyCnt = busy ? 1 : 0;
        while (!done && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busyCnt++;
        end
    endtask

    task automatic runAndCheck(input logic [31:0] va, input logic [31:0] vb, input logic vsub,
                               input logic [31:0] expS, input logic expCo, input logic expOvf,
                               input logic expZero, input bit idleAfter, input string tag);
        int lat;
        int busyCnt;
        applyStimulus(va, vb, vsub, lat, busyCnt);
        checkOutput({tag, " latency"}, lat, NSLICE);
        checkOutput({tag, " busyCycles"}, busyCnt, NSLICE);
        checkOutput({tag, " s"}, s, expS);
        checkOutput({tag, " co"}, {31'd0, co}, {31'd0, expCo});
        checkOutput({tag, " ovf"}, {31'd0, ovf}, {31'd0, expOvf});
        checkOutput({tag, " zero"}, {31'd0, zero}, {31'd0, expZero});
        if (idleAfter) begin
            @(posedge clk);
            #1;
            checkOutput({tag, " doneLowAfter"}, {31'd0, done}, 32'd0);
            checkOutput({tag, " sHeld"}, s, expS);
        end
    endtask

    initial begin
        vector_t vecs[6];
        logic [35:0] m;
        logic [31:0] ra;
        logic [31:0] rb;
        logic rsub;
        int lat;
        int busyCnt;
        int seen;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset s", s, 32'd0);
        checkOutput("reset co", {31'd0, co}, 32'd0);
        checkOutput("reset ovf", {31'd0, ovf}, 32'd0);
        checkOutput("reset zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            runAndCheck(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].expS, vecs[i].expCo,
                        vecs[i].expOvf, vecs[i].expZero, 1'b1, $sformatf("vec%0d", i));
        end

        // start held high through RUN with operands changing: must not re-latch.
        @(negedge clk);
        a = 32'd10;
        b = 32'd20;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h1234_5678;
        b = 32'h0F0F_0F0F;
        sub = 1'b1;
        lat = 0;
        while (!done && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        checkOutput("heldStart latency", lat, NSLICE);
        checkOutput("heldStart s", s, 32'd30);
        @(posedge clk);
        #1;
        checkOutput("heldStart idle", {31'd0, busy}, 32'd0);

        // Back-to-back: the second start lands in the DONE cycle of the first.
        runAndCheck(32'h0000_1000, 32'h0000_0234, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, "b2b first");
        runAndCheck(32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, "b2b second");

        // Reset asserted during the 4th RUN cycle aborts without a done pulse.
        runAndCheck(32'h0000_00AA, 32'h0000_0011, 1'b0, 32'h0000_00BB, 1'b0, 1'b0, 1'b0, 1'b1, "preAbort");
        @(negedge clk);
        a = 32'h1111_1111;
        b = 32'h2222_2222;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort s", s, 32'd0);
        checkOutput("abort co", {31'd0, co}, 32'd0);
        checkOutput("abort ovf", {31'd0, ovf}, 32'd0);
        checkOutput("abort zero", {31'd0, zero}, 32'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        checkOutput("abort noDone", seen, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: rb = 32'd0;
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            rsub = 1'($urandom_range(0, 1));
            m = refModel(ra, rb, rsub);
            runAndCheck(ra, rb, rsub, m[31:0], m[32], m[33], m[34],
                        1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
